// File: rtl/clint_itrp.sv
`default_nettype none
// ============================================================================
// Module   : clint_itrp
// Purpose  : Core-local interruptor. Holds msip / mtimecmp / mtime behind a
//            simple request/ack bus, derives the soft/timer/external pending
//            bits, and presents one held, one-hot interrupt request to the
//            trap logic until that request is taken or withdrawn.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            clint_req/wen/addr/      bus request (byte offset, byte-masked
//            wdata/wmask              64-bit writes)
//            clint_ack, clint_rdata   one-cycle completion pulse + read data
//            ext_irq                  level external interrupt source
//            mstatus_mie, mie_*       global and per-source enables
//            excp_enter               trap-entry acknowledge
//            itrp_info                one-hot request {ext, timer, soft}
// Revision : 1.0 - initial release
// ============================================================================
module clint_itrp #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_req,
    input  logic        clint_wen,
    input  logic [15:0] clint_addr,
    input  logic [63:0] clint_wdata,
    input  logic [7:0]  clint_wmask,
    output logic        clint_ack,
    output logic [63:0] clint_rdata,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_msie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        excp_enter,
    output logic [2:0]  itrp_info
);

    localparam logic [15:0] c_addr_msip     = 16'h0000;
    localparam logic [15:0] c_addr_mtimecmp = 16'h4000;
    localparam logic [15:0] c_addr_mtime    = 16'hBFF8;
    localparam logic [15:0] c_presc_max     = 16'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic        ack_q;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [15:0] presc_q, presc_d;
    logic        meip_q, mtip_q;
    logic [2:0]  info_q;

    logic        w_sample, w_write, w_tick;
    logic        w_sel_msip, w_sel_cmp, w_sel_time;
    logic [2:0]  w_en;
    logic [2:0]  w_pick;

    // Merge write data into a 64-bit register one byte lane at a time.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  mask);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // A new request is only taken while no ack is outstanding, which
    // limits throughput to one access every two cycles.
    assign w_sample   = clint_req & ~ack_q;
    assign w_write    = w_sample & clint_wen;
    assign w_sel_msip = (clint_addr == c_addr_msip);
    assign w_sel_cmp  = (clint_addr == c_addr_mtimecmp);
    assign w_sel_time = (clint_addr == c_addr_mtime);
    assign w_tick     = (presc_q == c_presc_max);

    // Enabled requests, bit order {ext, timer, soft}.
    assign w_en = {meip_q & mie_meie, mtip_q & mie_mtie, msip_q & mie_msie}
                  & {3{mstatus_mie}};

    // Priority external > soft > timer.
    always_comb begin
        w_pick = 3'b000;
        if (w_en[2])      w_pick = 3'b100;
        else if (w_en[0]) w_pick = 3'b001;
        else if (w_en[1]) w_pick = 3'b010;
    end

    always_comb begin
        presc_d    = w_tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = w_tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = 64'd0;

        // A software write to mtime wins over the tick; unwritten bytes
        // keep the pre-increment value.
        if (w_write && w_sel_time) mtime_d = byte_merge(mtime_q, clint_wdata, clint_wmask);
        if (w_write && w_sel_cmp)  mtimecmp_d = byte_merge(mtimecmp_q, clint_wdata, clint_wmask);
        if (w_write && w_sel_msip && clint_wmask[0]) msip_d = clint_wdata[0];

        if (w_sample && !clint_wen) begin
            if (w_sel_msip)      rdata_d = {63'd0, msip_q};
            else if (w_sel_cmp)  rdata_d = mtimecmp_q;
            else if (w_sel_time) rdata_d = mtime_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            rdata_q    <= 64'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            presc_q    <= 16'd0;
            meip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            info_q     <= 3'b000;
        end else begin
            ack_q      <= w_sample;
            rdata_q    <= rdata_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            presc_q    <= presc_d;
            meip_q     <= ext_irq;
            mtip_q     <= (mtime_q >= mtimecmp_q);

            case (state_q)
                ST_IDLE: begin
                    if (|w_en) begin
                        info_q  <= w_pick;
                        state_q <= ST_HOLD;
                    end else begin
                        info_q  <= 3'b000;
                    end
                end
                ST_HOLD: begin
                    // Trap entry takes precedence; otherwise drop the request
                    // if its own source is no longer enabled-pending.
                    if (excp_enter || !(|(w_en & info_q))) begin
                        info_q  <= 3'b000;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    info_q  <= 3'b000;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign clint_ack   = ack_q;
    assign clint_rdata = rdata_q;
    assign itrp_info   = info_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_itrp.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_itrp
// Purpose  : Directed self-checking bench for clint_itrp with TICK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_itrp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clint_req;
    logic        clint_wen;
    logic [15:0] clint_addr;
    logic [63:0] clint_wdata;
    logic [7:0]  clint_wmask;
    logic        clint_ack;
    logic [63:0] clint_rdata;
    logic        ext_irq;
    logic        mstatus_mie, mie_msie, mie_mtie, mie_meie;
    logic        excp_enter;
    logic [2:0]  itrp_info;

    int compared   = 0;
    int mismatched = 0;

    clint_itrp #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clint_req   (clint_req),
        .clint_wen   (clint_wen),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wmask (clint_wmask),
        .clint_ack   (clint_ack),
        .clint_rdata (clint_rdata),
        .ext_irq     (ext_irq),
        .mstatus_mie (mstatus_mie),
        .mie_msie    (mie_msie),
        .mie_mtie    (mie_mtie),
        .mie_meie    (mie_meie),
        .excp_enter  (excp_enter),
        .itrp_info   (itrp_info)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge two cycles later with the
    // bus idle again. Checks the ack pulse, its data, and its end.
    task automatic bus(input string tag, input logic wen, input logic [15:0] addr,
                       input logic [63:0] wd, input logic [7:0] wm,
                       input logic chk_rd, input logic [63:0] exp_rd);
        clint_req   = 1'b1;
        clint_wen   = wen;
        clint_addr  = addr;
        clint_wdata = wd;
        clint_wmask = wm;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack"}, {63'd0, clint_ack}, 64'd1);
        if (chk_rd) chk({tag, "_rd"}, clint_rdata, exp_rd);
        clint_req = 1'b0;
        clint_wen = 1'b0;
        @(negedge clk);
        chk({tag, "_ackend"}, {63'd0, clint_ack}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack",   {63'd0, clint_ack}, 64'd0);
        chk("rst_rdata", clint_rdata, 64'd0);
        chk("rst_info",  {61'd0, itrp_info}, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clint_req = 1'b0; clint_wen = 1'b0; clint_addr = '0;
        clint_wdata = '0; clint_wmask = '0; ext_irq = 1'b0; excp_enter = 1'b0;
        mstatus_mie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1; mie_meie = 1'b1;
        @(negedge clk);
        do_reset();

        // mtime counts one every 4 clocks from reset release.
        bus("mtime0", 1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b1, 64'd0);
        repeat (38) @(negedge clk);
        bus("mtime40", 1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b1, 64'd10);
        bus("cmp_rst", 1'b0, 16'h4000, 64'd0, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Timer interrupt at mtime = 20.
        bus("wr_cmp20", 1'b1, 16'h4000, 64'd20, 8'hFF, 1'b0, 64'd0);
        chk("pre_timer", {61'd0, itrp_info}, 64'd0);
        for (int i = 0; i < 200 && itrp_info !== 3'b010; i++) @(negedge clk);
        chk("timer_req", {61'd0, itrp_info}, 64'd2);
        bus("mtime_at_irq", 1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b1, 64'd20);
        repeat (3) @(negedge clk);
        chk("timer_hold", {61'd0, itrp_info}, 64'd2);
        excp_enter = 1'b1;
        @(negedge clk);
        excp_enter = 1'b0;
        chk("timer_taken", {61'd0, itrp_info}, 64'd0);
        @(negedge clk);
        chk("timer_rearb", {61'd0, itrp_info}, 64'd2);

        // Withdrawing the timer source drops the held request unaided.
        bus("wr_cmp_ones", 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 64'd0);
        @(negedge clk);
        chk("timer_drop", {61'd0, itrp_info}, 64'd0);
        repeat (2) @(negedge clk);
        chk("timer_stay0", {61'd0, itrp_info}, 64'd0);

        // All three sources pending together: external wins.
        mstatus_mie = 1'b0;
        ext_irq     = 1'b1;
        bus("wr_msip", 1'b1, 16'h0000, 64'h55, 8'h01, 1'b0, 64'd0);
        bus("rd_msip", 1'b0, 16'h0000, 64'd0, 8'h00, 1'b1, 64'd1);
        bus("wr_msip_m0", 1'b1, 16'h0000, 64'd0, 8'h00, 1'b0, 64'd0);
        bus("rd_msip_m0", 1'b0, 16'h0000, 64'd0, 8'h00, 1'b1, 64'd1);
        bus("wr_cmp0", 1'b1, 16'h4000, 64'd0, 8'hFF, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        chk("gmie_off", {61'd0, itrp_info}, 64'd0);
        mstatus_mie = 1'b1;
        @(negedge clk);
        chk("ext_first", {61'd0, itrp_info}, 64'd4);
        repeat (2) @(negedge clk);
        chk("ext_hold", {61'd0, itrp_info}, 64'd4);
        excp_enter = 1'b1;
        ext_irq    = 1'b0;
        @(negedge clk);
        excp_enter = 1'b0;
        chk("ext_taken", {61'd0, itrp_info}, 64'd0);
        @(negedge clk);
        chk("soft_next", {61'd0, itrp_info}, 64'd1);

        // Unmapped access and byte-masked writes.
        bus("rd_unmapped", 1'b0, 16'h1234, 64'd0, 8'h00, 1'b1, 64'd0);
        bus("wr_cmp_part", 1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 1'b0, 64'd0);
        bus("rd_cmp_part", 1'b0, 16'h4000, 64'd0, 8'h00, 1'b1, 64'h0000_0000_5566_7788);
        bus("wr_cmp_m0", 1'b1, 16'h4000, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0, 64'd0);
        bus("rd_cmp_m0", 1'b0, 16'h4000, 64'd0, 8'h00, 1'b1, 64'h0000_0000_5566_7788);

        // Reset landing on an in-flight msip write.
        clint_req = 1'b1; clint_wen = 1'b1; clint_addr = 16'h0000;
        clint_wdata = 64'd1; clint_wmask = 8'h01;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; clint_req = 1'b0; clint_wen = 1'b0;
        @(negedge clk);
        chk("inflight_ack",   {63'd0, clint_ack}, 64'd0);
        chk("inflight_rdata", clint_rdata, 64'd0);
        chk("inflight_info",  {61'd0, itrp_info}, 64'd0);
        rst = 1'b0;

        // mtime wrap: FE -> FF at tick 1, -> 0 at tick 2.
        bus("wr_mtime", 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, 64'd0);
        bus("rd_mtime_fe", 1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (5) @(negedge clk);
        bus("rd_mtime_wrap", 1'b0, 16'hBFF8, 64'd0, 8'h00, 1'b1, 64'd0);
        bus("rd_msip_rst", 1'b0, 16'h0000, 64'd0, 8'h00, 1'b1, 64'd0);
        chk("final_info", {61'd0, itrp_info}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
